ca_row_store: RTL and testbench

- Tear-free row store between the cellular-automaton generator and the VGA pixel pipeline.
- Accepts one new automaton generation per handshake and holds it in a one-entry pending buffer.
- Commits the pending row to a ROWS x WIDTH bit store only at frame boundaries.
- Serves single pixels to the video side with 1-cycle latency; optional scroll mode shows the oldest row at the top.

---
 rtl/ca_pkg.sv | 16 +
 rtl/ca_row_store_if.sv | 32 +++
 rtl/ca_row_mem.sv | 28 ++
 rtl/ca_row_store.sv | 112 +++++++++++
 tb/tb_ca_row_store.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/ca_pkg.sv
// Shared constants and helpers for the cellular-automaton row store.
package ca_pkg;

    localparam int unsigned CA_WIDTH = 80;
    localparam int unsigned CA_ROWS  = 60;
    localparam int unsigned CA_AW    = 7;

    // Modular add for row indices already below rows: one conditional subtract, no divider.
    function automatic int unsigned row_add(input int unsigned a, input int unsigned b,
                                            input int unsigned rows);
        int unsigned sum;
        sum = a + b;
        return (sum >= rows) ? sum - rows : sum;
    endfunction

endpackage

// File: rtl/ca_row_store_if.sv
// Generator-side write handshake and video-side pixel read bundle for ca_row_store.
interface ca_row_store_if
    import ca_pkg::*;
#(
    parameter int unsigned WIDTH = CA_WIDTH,
    parameter int unsigned AW    = CA_AW
);

    logic             wr_valid;
    logic             wr_ready;
    logic [WIDTH-1:0] wr_data;
    logic             frame_start;
    logic             mode_scroll;
    logic             rd_en;
    logic [AW-1:0]    rd_row;
    logic [AW-1:0]    rd_col;
    logic             rd_pixel;
    logic             rd_valid;
    logic             row_committed;
    logic [AW-1:0]    fill_count;

    modport master (
        output wr_valid, wr_data, frame_start, mode_scroll, rd_en, rd_row, rd_col,
        input  wr_ready, rd_pixel, rd_valid, row_committed, fill_count
    );

    modport slave (
        input  wr_valid, wr_data, frame_start, mode_scroll, rd_en, rd_row, rd_col,
        output wr_ready, rd_pixel, rd_valid, row_committed, fill_count
    );

endinterface

// File: rtl/ca_row_mem.sv
// Simple dual-port ROWS x WIDTH row memory, synchronous read-first word read.
module ca_row_mem #(
    parameter int unsigned WIDTH = 80,
    parameter int unsigned ROWS  = 60,
    parameter int unsigned RW    = 6
) (
    input  logic             clk,
    input  logic             we,
    input  logic [RW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic             re,
    input  logic [RW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [ROWS];

    // No reset on purpose so the array maps onto block RAM.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/ca_row_store.sv
// Tear-free row store: one pending generation, committed to the row memory at frame start.
module ca_row_store
    import ca_pkg::*;
#(
    parameter int unsigned WIDTH = CA_WIDTH,
    parameter int unsigned ROWS  = CA_ROWS,
    parameter int unsigned AW    = CA_AW
) (
    input logic           clk,
    input logic           rst,
    ca_row_store_if.slave bus
);

    localparam int unsigned RW = $clog2(ROWS);

    logic             pend_q;
    logic [WIDTH-1:0] pend_data_q;
    logic [AW-1:0]    head_q;
    logic [AW-1:0]    fill_q;
    logic             lmode_q;
    logic             rd_valid_q;
    logic             blank_q;
    logic [AW-1:0]    col_q;

    logic             accept;
    logic             commit;
    logic             scroll;
    logic             blank;
    logic [RW-1:0]    phys_row;
    logic [AW-1:0]    bit_idx;
    logic [WIDTH-1:0] rdata;

    assign accept = bus.wr_valid && !pend_q;
    assign commit = bus.frame_start && pend_q && !rst;
    assign scroll = lmode_q && (fill_q == AW'(ROWS));

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q  <= 1'b0;
            head_q  <= '0;
            fill_q  <= '0;
            lmode_q <= 1'b0;
        end else begin
            if (commit) begin
                pend_q <= 1'b0;
                head_q <= (head_q == AW'(ROWS - 1)) ? '0 : head_q + 1'b1;
                if (fill_q != AW'(ROWS)) begin
                    fill_q <= fill_q + 1'b1;
                end
            end else if (accept) begin
                pend_q <= 1'b1;
            end
            if (bus.frame_start) begin
                lmode_q <= bus.mode_scroll;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            pend_data_q <= bus.wr_data;
        end
    end

    // Scroll mode puts the oldest row (at head) on display row 0.
    always_comb begin
        phys_row = bus.rd_row[RW-1:0];
        if (scroll) begin
            phys_row = RW'(row_add(32'(head_q), 32'(bus.rd_row), ROWS));
        end
        blank = (32'(bus.rd_row) >= ROWS) || (32'(bus.rd_col) >= WIDTH) ||
                (!scroll && (bus.rd_row >= fill_q));
    end

    // blank_q resets high so rd_pixel is 0 out of reset without clearing the RAM.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid_q <= 1'b0;
            blank_q    <= 1'b1;
        end else begin
            rd_valid_q <= bus.rd_en;
            if (bus.rd_en) begin
                blank_q <= blank;
                col_q   <= bus.rd_col;
            end
        end
    end

    ca_row_mem #(
        .WIDTH (WIDTH),
        .ROWS  (ROWS),
        .RW    (RW)
    ) u_mem (
        .clk   (clk),
        .we    (commit),
        .waddr (head_q[RW-1:0]),
        .wdata (pend_data_q),
        .re    (bus.rd_en),
        .raddr (phys_row),
        .rdata (rdata)
    );

    // Column 0 is the MSB of the stored word.
    assign bit_idx = AW'(WIDTH - 1) - col_q;

    assign bus.wr_ready      = !pend_q;
    assign bus.row_committed = commit;
    assign bus.fill_count    = fill_q;
    assign bus.rd_valid      = rd_valid_q;
    assign bus.rd_pixel      = !blank_q && rdata[bit_idx];

endmodule

// File: tb/tb_ca_row_store.sv
// Directed bench for ca_row_store: pixel reads checked through a scoreboard queue.
module tb_ca_row_store;
    import ca_pkg::*;

    localparam int unsigned W = CA_WIDTH;
    localparam int unsigned R = CA_ROWS;
    localparam int unsigned A = CA_AW;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ca_row_store_if #(.WIDTH(W), .AW(A)) bus ();

    ca_row_store #(
        .WIDTH (W),
        .ROWS  (R),
        .AW    (A)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    bit          sb[$];
    bit          pend_m;
    int unsigned fill_m;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: check handshake outputs against the small model, then advance it.
    task automatic step();
        bit com;
        bit acc;
        com = bus.frame_start && pend_m && !rst;
        acc = bus.wr_valid && !pend_m && !rst;
        #1;
        check("row_committed", 32'(bus.row_committed), 32'(com));
        check("wr_ready", 32'(bus.wr_ready), 32'(!pend_m));
        check("fill_count", 32'(bus.fill_count), fill_m);
        @(posedge clk);
        if (rst) begin
            pend_m = 1'b0;
            fill_m = 0;
        end else begin
            if (com) begin
                pend_m = 1'b0;
                if (fill_m < R) fill_m++;
            end
            if (acc) pend_m = 1'b1;
        end
        #1;
    endtask

    task automatic rd(input int unsigned r, input int unsigned c, input bit exp);
        bus.rd_en  = 1'b1;
        bus.rd_row = A'(r);
        bus.rd_col = A'(c);
        sb.push_back(exp);
        step();
        bus.rd_en = 1'b0;
    endtask

    task automatic write_row(input logic [W-1:0] v);
        bus.wr_valid = 1'b1;
        bus.wr_data  = v;
        step();
        bus.wr_valid = 1'b0;
    endtask

    always @(negedge clk) begin
        if (bus.rd_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("rd_valid_unexpected", 32'(bus.rd_valid), 32'd0);
            end else begin
                check("rd_pixel", 32'(bus.rd_pixel), 32'(sb.pop_front()));
            end
        end
    end

    initial begin
        logic [W-1:0] col0;
        col0        = '0;
        col0[W-1]   = 1'b1;
        rst             = 1'b1;
        bus.wr_valid    = 1'b0;
        bus.wr_data     = '0;
        bus.frame_start = 1'b0;
        bus.mode_scroll = 1'b0;
        bus.rd_en       = 1'b0;
        bus.rd_row      = '0;
        bus.rd_col      = '0;
        pend_m          = 1'b0;
        fill_m          = 0;
        @(posedge clk);
        #1;
        step();
        rst = 1'b0;

        // Empty store reads 0 everywhere, including out-of-range coordinates.
        for (int r = 0; r < 62; r++) begin
            for (int c = 0; c < 82; c++) begin
                rd(r, c, 1'b0);
            end
        end
        step();
        check("rd_valid_idle", 32'(bus.rd_valid), 32'd0);

        // Pending row is invisible until frame_start; second offer is ignored.
        bus.wr_valid = 1'b1;
        bus.wr_data  = col0;
        step();
        bus.wr_data = W'(1);
        step();
        step();
        bus.wr_valid = 1'b0;
        rd(0, 0, 1'b0);
        rd(0, 79, 1'b0);
        for (int i = 0; i < 4; i++) step();
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        rd(0, 0, 1'b1);
        rd(0, 1, 1'b0);
        rd(0, 79, 1'b0);
        rd(1, 0, 1'b0);

        // Acceptance together with frame_start: commit waits for the next frame.
        bus.wr_valid    = 1'b1;
        bus.wr_data     = '1;
        bus.frame_start = 1'b1;
        step();
        bus.wr_valid    = 1'b0;
        bus.frame_start = 1'b0;
        step();
        rd(1, 0, 1'b0);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        rd(1, 0, 1'b1);
        rd(1, 79, 1'b1);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;

        // 62 commits with value k: rows 0/1 overwritten by 60/61, head ends at 2.
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int k = 0; k < 62; k++) begin
            write_row(W'(k));
            bus.frame_start = 1'b1;
            step();
            bus.frame_start = 1'b0;
        end
        rd(0, 79, 1'b0);
        rd(0, 77, 1'b1);
        rd(0, 73, 1'b0);
        rd(1, 79, 1'b1);
        rd(1, 78, 1'b0);
        rd(2, 78, 1'b1);
        rd(2, 79, 1'b0);
        rd(59, 77, 1'b0);
        rd(59, 79, 1'b1);
        rd(0, 0, 1'b0);

        // Scroll request mid-frame takes effect only at the next frame_start.
        bus.mode_scroll = 1'b1;
        step();
        rd(0, 78, 1'b0);
        rd(59, 79, 1'b1);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        rd(0, 78, 1'b1);
        rd(0, 79, 1'b0);
        rd(59, 79, 1'b1);
        rd(59, 78, 1'b0);
        rd(1, 78, 1'b1);
        rd(57, 76, 1'b1);
        rd(57, 77, 1'b0);
        rd(58, 77, 1'b1);
        rd(58, 79, 1'b0);
        rd(60, 0, 1'b0);
        rd(0, 80, 1'b0);

        // Read and commit on the same physical row return the old word.
        write_row('1);
        bus.frame_start = 1'b1;
        rd(0, 79, 1'b0);
        bus.frame_start = 1'b0;
        rd(0, 79, 1'b1);
        rd(0, 78, 1'b1);
        rd(59, 0, 1'b1);
        rd(59, 79, 1'b1);
        step();
        step();
        check("rd_pixel_hold", 32'(bus.rd_pixel), 32'd1);
        check("rd_valid_hold", 32'(bus.rd_valid), 32'd0);

        // Reset with a pending row and reads in flight.
        bus.mode_scroll = 1'b0;
        write_row('1);
        rd(5, 79, 1'b0);
        rd(5, 76, 1'b1);
        bus.rd_en  = 1'b1;
        bus.rd_row = '0;
        bus.rd_col = '0;
        rst        = 1'b1;
        step();
        rst       = 1'b0;
        bus.rd_en = 1'b0;
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_pixel", 32'(bus.rd_pixel), 32'd0);
        bus.frame_start = 1'b1;
        step();
        bus.frame_start = 1'b0;
        rd(0, 0, 1'b0);
        rd(59, 79, 1'b0);
        step();
        step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
